if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch.sv | 124 ++++++++++++
 tb/tb_if_prefetch.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch queue: keeps up to DEPTH instruction words fetched
// ahead of decode, with redirect flush and a single-outstanding memory handshake.
module if_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic          issue;
    logic          enq;
    logic          deq;

    // Redirect overrides everything: no issue, no enqueue, no dequeue that cycle.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        enq       = 1'b0;
        deq       = inst_valid_o && !stall_i && !redirect_i;
        case (state)
            S_IDLE: begin
                if (!redirect_i && start_i && (count < FULL)) begin
                    state_nxt = S_REQ;
                    issue     = 1'b1;
                end
            end
            S_REQ: begin
                if (mem_ack_i) begin
                    state_nxt = S_IDLE;
                    enq       = !redirect_i;
                end else if (redirect_i) begin
                    state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (mem_ack_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= 32'h0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                req_addr <= fetch_pc;
            end
            if (redirect_i) begin
                fetch_pc <= redirect_pc_i;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (enq) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    wr_ptr   <= wr_ptr + 1'b1;
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (enq && !deq) begin
                    count <= count + 1'b1;
                end else if (!enq && deq) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Queue storage needs no reset; the outputs are gated by the occupancy count.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            inst_q[wr_ptr] <= mem_data_i;
            pc_q[wr_ptr]   <= req_addr;
        end
    end

    assign mem_req_o    = (state != S_IDLE);
    assign mem_addr_o   = req_addr;
    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? inst_q[rd_ptr] : 32'h0;
    assign pc_o         = inst_valid_o ? (pc_q[rd_ptr] + 32'd4) : 32'h0;

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: a latency-randomised memory model, an
// expected-stream queue of fetch addresses, and a decoupled monitor.
module tb_if_prefetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_pops = 0;
    int          lat_lo = 0;
    int          lat_hi = 0;
    logic        stray = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] ack_log[$];

    if_prefetch dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .start_i      (start),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .stall_i      (stall),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack),
        .mem_data_i   (mem_data),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .pc_o         (pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // The delivered stream restarts at a new address after each redirect or reset.
    task automatic sbRestart(input logic [31:0] addr);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(addr + 32'(4 * i));
    endtask

    task automatic applyStimulus(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        sbRestart(target);
        tick();
        redirect = 1'b0;
    endtask

    task automatic waitAck(input string name);
        int i;
        for (i = 0; i < 40 && !mem_ack; i++) tick();
        if (!mem_ack) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: no ack within 40 cycles (got 0 expected 1)", name);
        end
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_req"}, 32'(mem_req_o), 32'h0);
        checkOutput({tag, "_addr"}, mem_addr_o, 32'h0);
        checkOutput({tag, "_valid"}, 32'(inst_valid_o), 32'h0);
        checkOutput({tag, "_inst"}, inst_o, 32'h0);
        checkOutput({tag, "_pc"}, pc_o, 32'h0);
    endtask

    // Memory: acks each request after a random latency in [lat_lo, lat_hi].
    initial begin
        logic busy;
        int   cnt;
        busy = 1'b0;
        cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stray) begin
                mem_ack  = 1'b1;
                mem_data = 32'hDEAD_BEEF;
            end else if (mem_req_o) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = $urandom_range(lat_hi, lat_lo);
                end
                if (cnt == 0) begin
                    mem_ack  = 1'b1;
                    mem_data = word_of(mem_addr_o);
                    ack_log.push_back(mem_addr_o);
                    busy = 1'b0;
                end else begin
                    mem_ack = 1'b0;
                    cnt--;
                end
            end else begin
                mem_ack = 1'b0;
                busy    = 1'b0;
            end
        end
    end

    // Monitor: handshake stability and in-order delivery of the expected stream.
    initial begin
        logic        prev_rst;
        logic        prev_req;
        logic        prev_ack;
        logic [31:0] prev_addr;
        logic [31:0] e;
        prev_rst  = 1'b0;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && prev_rst && prev_req && !prev_ack) begin
                checkOutput("req_held", 32'(mem_req_o), 32'h1);
                checkOutput("addr_stable", mem_addr_o, prev_addr);
            end
            if (rst_n && inst_valid_o && !stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_inst: got pc %h expected none", pc_o);
                end else begin
                    if (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
                    e = exp_q.pop_front();
                    n_pops++;
                    checkOutput("head_pc", pc_o, e + 32'd4);
                    checkOutput("head_inst", inst_o, word_of(e));
                end
            end
            prev_rst  = rst_n;
            prev_req  = mem_req_o;
            prev_ack  = mem_ack;
            prev_addr = mem_addr_o;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout expected finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit saw_valid;

        // Reset values while reset is held
        #1 rst_n = 1'b0;
        start = 1'b1;
        stall = 1'b1;
        #2 checkZero("reset");
        tick();
        tick();

        // Sequential fetch from RESET_PC, one-cycle latency to the queue head
        lat_lo = 0;
        lat_hi = 0;
        ack_log.delete();
        sbRestart(32'h0);
        rst_n = 1'b1;
        checkOutput("no_early_req", 32'(mem_req_o), 32'h0);
        waitAck("first_ack");
        checkOutput("first_addr", mem_addr_o, 32'h0);
        checkOutput("no_bypass", 32'(inst_valid_o), 32'h0);
        tick();
        checkOutput("first_valid", 32'(inst_valid_o), 32'h1);
        checkOutput("first_pc", pc_o, 32'h4);
        checkOutput("first_inst", inst_o, word_of(32'h0));

        // Stall fills exactly DEPTH entries, then drains in order and fetch resumes at 16
        for (int i = 0; i < 15; i++) tick();
        checkOutput("fill_count", 32'(ack_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            checkOutput("fill_addr", ack_log[i], 32'(4 * i));
        checkOutput("full_no_req", 32'(mem_req_o), 32'h0);
        stall = 1'b0;
        waitAck("resume_ack");
        checkOutput("resume_addr", mem_addr_o, 32'h10);
        tick();

        // Redirect to 0x100 while the request to 8 is outstanding
        stall  = 1'b1;
        lat_lo = 4;
        lat_hi = 4;
        applyStimulus(32'h8);
        for (int i = 0; i < 30 && !(mem_req_o && mem_addr_o == 32'h8 && !mem_ack); i++) tick();
        checkOutput("req8_out", 32'(mem_req_o && mem_addr_o == 32'h8), 32'h1);
        ack_log.delete();
        applyStimulus(32'h100);
        saw_valid = 1'b0;
        for (int i = 0; i < 40 && ack_log.size() < 2; i++) begin
            if (inst_valid_o) saw_valid = 1'b1;
            tick();
        end
        if (inst_valid_o) saw_valid = 1'b1;
        checkOutput("discard_valid", 32'(saw_valid), 32'h0);
        checkOutput("discard_acks", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() >= 2) begin
            checkOutput("dropped_addr", ack_log[0], 32'h8);
            checkOutput("redirect_addr", ack_log[1], 32'h100);
        end
        tick();
        checkOutput("redirect_valid", 32'(inst_valid_o), 32'h1);
        checkOutput("redirect_pc", pc_o, 32'h104);

        // Redirect coinciding with an ack and a dequeue
        lat_lo = 0;
        lat_hi = 0;
        applyStimulus(32'h40);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 20 && !(mem_ack && inst_valid_o); i++) tick();
        checkOutput("collide_setup", 32'(mem_ack && inst_valid_o), 32'h1);
        stall = 1'b0;
        ack_log.delete();
        applyStimulus(32'h200);
        stall = 1'b1;
        checkOutput("collide_empty", 32'(inst_valid_o), 32'h0);
        waitAck("collide_ack");
        checkOutput("collide_addr", mem_addr_o, 32'h200);

        // Address wrap past 0xFFFFFFFC
        ack_log.delete();
        applyStimulus(32'hFFFF_FFF8);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("wrap_acks", 32'(ack_log.size() >= 3), 32'h1);
        if (ack_log.size() >= 3) begin
            checkOutput("wrap_a0", ack_log[0], 32'hFFFF_FFF8);
            checkOutput("wrap_a1", ack_log[1], 32'hFFFF_FFFC);
            checkOutput("wrap_a2", ack_log[2], 32'h0);
        end
        checkOutput("wrap_head_pc", pc_o, 32'hFFFF_FFFC);
        stall = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Reset pulse mid-request, stray ack afterwards, restart at RESET_PC
        lat_lo = 4;
        lat_hi = 4;
        for (int i = 0; i < 20 && !mem_req_o; i++) tick();
        checkOutput("mid_req", 32'(mem_req_o), 32'h1);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1 checkZero("async_reset");
        tick();
        tick();
        start = 1'b0;
        rst_n = 1'b1;
        sbRestart(32'h0);
        ack_log.delete();
        tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        checkOutput("stray_valid", 32'(inst_valid_o), 32'h0);
        checkOutput("stray_req", 32'(mem_req_o), 32'h0);
        checkOutput("stray_log", 32'(ack_log.size()), 32'h0);
        lat_lo = 0;
        lat_hi = 0;
        start  = 1'b1;
        waitAck("restart_ack");
        checkOutput("restart_addr", mem_addr_o, 32'h0);

        // Randomised traffic against the expected-stream scoreboard
        lat_lo = 0;
        lat_hi = 3;
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom & 32'hFFFF_FFFC;
                sbRestart(redirect_pc);
            end else begin
                redirect = 1'b0;
            end
            tick();
        end
        redirect = 1'b0;
        start    = 1'b1;
        stall    = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        checkOutput("enough_pops", 32'(n_pops > 100), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
